sprite_line_render: RTL
=======================

Name: sprite_line_render

Overview:
- Downstream of the per-line sprite selector: consumes its slot list (up to MAX_OBJECTS OAM indices with valid bits) once it signals line ready.
- Fetches each selected OAM entry and the matching 16-pixel sprite row, then draws them into a double-buffered line buffer.
- Streams the previously rendered line to the pixel compositor, indexed by sx.
- Top level drives sy with the line being prepared (display line + 1). The front buffer therefore always holds the line currently on screen.

Parameters:
- MAX_OBJECTS, 4, slot count in buffer_entries
- LINE_WIDTH, 640, visible pixels per line (line buffer depth)
- SPRITE_SIZE, 16, sprite width/height in pixels (fixed 16; rows indexed by 4 bits)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sx  in  10  current display column
- sy  in  10  line being prepared
- line_prepared  in  1  selector finished for current sy
- buffer_entries  in  MAX_OBJECTS*9  slot i at [9i+8:9i]; bit0 = valid, [8:1] = OAM index
- oam_addr  out  6  OAM read address (1-cycle read latency)
- oam_data  in  32  [31] enable, [30] yflip, [29] xflip, [28] priority, [27:18] y, [17:8] x, [7:0] spriteref
- spr_addr  out  12  {spriteref, row[3:0]} (1-cycle read latency)
- spr_data  in  64  pixel p at [4p+3:4p]; p=0 is leftmost; colour 0 = transparent
- pix_color  out  4  front-buffer colour at sx
- pix_priority  out  1  priority bit of that pixel
- pix_valid  out  1  pix_color != 0 and sx < LINE_WIDTH
- line_done  out  1  back buffer fully rendered for current sy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. All outputs are registered.
- Reset values: pix_color=0, pix_priority=0, pix_valid=0, line_done=0, oam_addr=0, spr_addr=0. Reset enters CLEAR.
- Line buffers: two LINE_WIDTH x 5-bit buffers, entry = {priority, colour}. front_sel selects the display buffer.
- Display path, 1-cycle latency: pixel outputs at cycle t+1 reflect front[sx] sampled at t. When sx < LINE_WIDTH, front[sx] is written to 0 in the same cycle (read-clear), so a swapped-in buffer is always clean. When sx >= LINE_WIDTH, outputs are 0.
- Line change: registered last_sy. When sy != last_sy:
  - front_sel toggles;
  - line_done clears;
  - FSM goes to HOLD, aborting any in-progress render mid-sprite;
  - partially drawn data in the new front buffer is displayed as-is.
- FSM states and transitions:
  - CLEAR: writes 0 to both buffers at address 0..LINE_WIDTH-1, one address per cycle, then goes to HOLD.
  - HOLD: 2 cycles, ignoring line_prepared while the upstream clears it, then goes to WAIT_PREP.
  - WAIT_PREP: slot=0. Waits for line_prepared=1, then goes to SCAN.
  - SCAN: if slot==MAX_OBJECTS, go to DONE. If slot is invalid, go to DONE (slots are packed). Otherwise drive oam_addr=index[5:0] and go to OAM_WAIT.
  - OAM_WAIT: 1 cycle. Then latch oam_data and go to ROW_REQ.
  - ROW_REQ:
    - row = (sy - y)[3:0];
    - if the OAM enable bit is 0, slot++ and return to SCAN;
    - otherwise drive spr_addr and go to ROW_WAIT.
  - ROW_WAIT: 1 cycle. Then latch spr_data and go to DRAW with p=0.
  - DRAW: one pixel per cycle, p=0..15.
    - target X = x + p, computed as an 11-bit sum.
    - Write the back buffer only if colour != 0, X < LINE_WIDTH, and back[X].colour == 0. Lower slot therefore wins.
    - After p=15: slot++, return to SCAN.
  - DONE: line_done=1; stays until a line change.
- Timing: per-sprite cost 20 cycles, worst case 2+MAX_OBJECTS*20+2 cycles per line.
- Boundary conditions:
  - Sprite partly off right edge: clipped pixels are dropped, not wrapped.
  - x >= LINE_WIDTH: nothing drawn.
  - sy change during DRAW: the remaining pixels of that sprite are discarded.
  - Reset mid-line: CLEAR reruns. Outputs read 0 while CLEAR runs.

Optional Feature:
- Macro: SPRITE_FLIP_EN.
- Defined: yflip selects row = 15 - row; xflip draws pixel p from source 15 - p.
- Undefined: bits 30/29 are ignored and sprites are always drawn unflipped. The flip logic is not synthesized.

Test Plan:
- Reset, then hold 640 cycles -> CLEAR finishes; sweep sx 0..639 -> pix_valid=0 everywhere.
- sy=20; slot0={idx3, valid}; OAM[3]: en=1, x=100, y=15, ref=7; spr_data pixel p = p (so p=0 is transparent); line_prepared; then sy=21 -> spr_addr observed 0x075; during line 21, sx=101..115 give colours 1..15 and sx=100 has pix_valid=0.
- Two sprites overlapping at x=200: slot0 colour 5, slot1 colour 9, all pixels opaque -> overlap region shows 5.
- Sprite at x=630 -> pixels at 630..639 drawn; no write at 0..5; line_done asserts within 90 cycles.
- sy changes during DRAW of slot1 -> FSM enters HOLD; next line's buffer starts clean (read-clear verified by a second sweep showing 0).
- SPRITE_FLIP_EN defined, OAM xflip=1 -> sx=100 shows colour 15; undefined -> sx=100 transparent.

Source files
------------

// File: rtl/sprite_line_render.sv
// Per-line sprite renderer: fetches OAM entries and sprite rows, draws them into a
// double-buffered line buffer and streams the front buffer by sx. Optional flip: SPRITE_FLIP_EN.
module sprite_line_render #(
    parameter int MAX_OBJECTS = 4,
    parameter int LINE_WIDTH  = 640,
    parameter int SPRITE_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               sx,
    input  logic [9:0]               sy,
    input  logic                     line_prepared,
    input  logic [MAX_OBJECTS*9-1:0] buffer_entries,
    output logic [5:0]               oam_addr,
    input  logic [31:0]              oam_data,
    output logic [11:0]              spr_addr,
    input  logic [63:0]              spr_data,
    output logic [3:0]               pix_color,
    output logic                     pix_priority,
    output logic                     pix_valid,
    output logic                     line_done
);

    localparam int SW = $clog2(MAX_OBJECTS + 1);
    localparam int PW = $clog2(SPRITE_SIZE);

    localparam logic [3:0] S_CLEAR     = 4'd0;
    localparam logic [3:0] S_HOLD      = 4'd1;
    localparam logic [3:0] S_WAIT_PREP = 4'd2;
    localparam logic [3:0] S_SCAN      = 4'd3;
    localparam logic [3:0] S_OAM_WAIT  = 4'd4;
    localparam logic [3:0] S_ROW_REQ   = 4'd5;
    localparam logic [3:0] S_ROW_WAIT  = 4'd6;
    localparam logic [3:0] S_DRAW      = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    // Line buffer entry = {priority, colour}; r_front_sel=0 means r_buf0 is on screen.
    logic [4:0]    r_buf0 [LINE_WIDTH];
    logic [4:0]    r_buf1 [LINE_WIDTH];

    logic [3:0]    r_state;
    logic [9:0]    r_last_sy;
    logic [9:0]    r_clr_addr;
    logic          r_hold_cnt;
    logic [SW-1:0] r_slot;
    logic [PW-1:0] r_p;
    logic          r_front_sel;
    logic [31:0]   r_oam;
    logic [63:0]   r_row;
    logic [5:0]    r_oam_addr;
    logic [11:0]   r_spr_addr;
    logic [3:0]    r_pix_color;
    logic          r_pix_priority;
    logic          r_pix_valid;
    logic          r_line_done;

    logic          w_line_chg;
    logic [8:0]    w_entry;
    logic [9:0]    w_row_diff;
    logic [3:0]    w_row;
    logic [PW-1:0] w_src;
    logic [3:0]    w_colour;
    logic [10:0]   w_draw_x;
    logic          w_x_in;
    logic [9:0]    w_rd_idx;
    logic [3:0]    w_back_col;
    logic          w_draw_we;
    logic [4:0]    w_draw_data;
    logic          w_sx_in;
    logic [9:0]    w_sx_idx;
    logic [4:0]    w_front_pix;
    logic          w_clr_we;
    logic          w_unused;

    assign w_line_chg = (sy != r_last_sy);

    always_comb begin
        w_entry = '0;
        for (int i = 0; i < MAX_OBJECTS; i++) begin
            if (r_slot == SW'(i)) w_entry = buffer_entries[9*i +: 9];
        end
    end

    always_comb begin
        w_row_diff = sy - r_oam[27:18];
`ifdef SPRITE_FLIP_EN
        w_row = r_oam[30] ? ~w_row_diff[3:0] : w_row_diff[3:0];
        w_src = r_oam[29] ? ~r_p : r_p;
`else
        w_row = w_row_diff[3:0];
        w_src = r_p;
`endif
    end

    assign w_colour    = r_row[{w_src, 2'b00} +: 4];
    assign w_draw_x    = {1'b0, r_oam[17:8]} + 11'(r_p);
    assign w_x_in      = w_draw_x < 11'(LINE_WIDTH);
    assign w_rd_idx    = w_x_in ? w_draw_x[9:0] : 10'd0;
    assign w_back_col  = r_front_sel ? r_buf0[w_rd_idx][3:0] : r_buf1[w_rd_idx][3:0];
    // A pending line change discards the pixel being drawn this cycle.
    assign w_draw_we   = (r_state == S_DRAW) && !w_line_chg && (w_colour != 4'd0)
                         && w_x_in && (w_back_col == 4'd0);
    assign w_draw_data = {r_oam[28], w_colour};

    assign w_sx_in     = sx < 10'(LINE_WIDTH);
    assign w_sx_idx    = w_sx_in ? sx : 10'd0;
    assign w_front_pix = r_front_sel ? r_buf1[w_sx_idx] : r_buf0[w_sx_idx];
    assign w_clr_we    = (r_state == S_CLEAR);

    assign w_unused = &{1'b0, w_entry[8:7], w_row_diff[9:4], r_oam[30:29], 1'b0};

    // Front buffer is read-cleared as it is displayed; back buffer takes draw writes.
    always_ff @(posedge clk) begin
        if (w_clr_we)
            r_buf0[r_clr_addr] <= 5'd0;
        else if (!r_front_sel && w_sx_in)
            r_buf0[w_sx_idx] <= 5'd0;
        else if (r_front_sel && w_draw_we)
            r_buf0[w_rd_idx] <= w_draw_data;
    end

    always_ff @(posedge clk) begin
        if (w_clr_we)
            r_buf1[r_clr_addr] <= 5'd0;
        else if (r_front_sel && w_sx_in)
            r_buf1[w_sx_idx] <= 5'd0;
        else if (!r_front_sel && w_draw_we)
            r_buf1[w_rd_idx] <= w_draw_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_color    <= 4'd0;
            r_pix_priority <= 1'b0;
            r_pix_valid    <= 1'b0;
        end else if (w_sx_in && r_state != S_CLEAR) begin
            r_pix_color    <= w_front_pix[3:0];
            r_pix_priority <= w_front_pix[4];
            r_pix_valid    <= (w_front_pix[3:0] != 4'd0);
        end else begin
            r_pix_color    <= 4'd0;
            r_pix_priority <= 1'b0;
            r_pix_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_OAM_WAIT) r_oam <= oam_data;
        if (r_state == S_ROW_WAIT) r_row <= spr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_CLEAR;
            r_last_sy   <= sy;
            r_clr_addr  <= 10'd0;
            r_hold_cnt  <= 1'b0;
            r_slot      <= '0;
            r_p         <= '0;
            r_front_sel <= 1'b0;
            r_line_done <= 1'b0;
            r_oam_addr  <= 6'd0;
            r_spr_addr  <= 12'd0;
        end else begin
            r_last_sy <= sy;
            if (w_line_chg) begin
                r_front_sel <= ~r_front_sel;
                r_line_done <= 1'b0;
            end
            // CLEAR wipes both buffers anyway, so it is not interrupted by a line change.
            if (w_line_chg && r_state != S_CLEAR) begin
                r_state    <= S_HOLD;
                r_hold_cnt <= 1'b0;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        if (r_clr_addr == 10'(LINE_WIDTH - 1)) begin
                            r_clr_addr <= 10'd0;
                            r_hold_cnt <= 1'b0;
                            r_state    <= S_HOLD;
                        end else begin
                            r_clr_addr <= r_clr_addr + 10'd1;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt) r_state <= S_WAIT_PREP;
                        r_hold_cnt <= 1'b1;
                    end
                    S_WAIT_PREP: begin
                        r_slot <= '0;
                        if (line_prepared) r_state <= S_SCAN;
                    end
                    S_SCAN: begin
                        if (r_slot == SW'(MAX_OBJECTS) || !w_entry[0]) begin
                            r_line_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_oam_addr <= w_entry[6:1];
                            r_state    <= S_OAM_WAIT;
                        end
                    end
                    S_OAM_WAIT: r_state <= S_ROW_REQ;
                    S_ROW_REQ: begin
                        if (!r_oam[31]) begin
                            r_slot  <= r_slot + SW'(1);
                            r_state <= S_SCAN;
                        end else begin
                            r_spr_addr <= {r_oam[7:0], w_row};
                            r_state    <= S_ROW_WAIT;
                        end
                    end
                    S_ROW_WAIT: begin
                        r_p     <= '0;
                        r_state <= S_DRAW;
                    end
                    S_DRAW: begin
                        if (r_p == PW'(SPRITE_SIZE - 1)) begin
                            r_slot  <= r_slot + SW'(1);
                            r_state <= S_SCAN;
                        end else begin
                            r_p <= r_p + PW'(1);
                        end
                    end
                    S_DONE:  r_line_done <= 1'b1;
                    default: r_state <= S_CLEAR;
                endcase
            end
        end
    end

    assign oam_addr     = r_oam_addr;
    assign spr_addr     = r_spr_addr;
    assign pix_color    = r_pix_color;
    assign pix_priority = r_pix_priority;
    assign pix_valid    = r_pix_valid;
    assign line_done    = r_line_done;

endmodule
